// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and
// datapath mux/ALU select values.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12,
      S_HALT      = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Instruction class dispatch out of DECODE; unknown opcodes halt the core.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_R_EXEC;
         OP_LW, OP_SW: return S_MEM_ADDR;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_ADDI_EXEC;
         default:      return S_HALT;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory-wait cycles and flags a timeout on the
// cycle the count reaches MEM_TIMEOUT (MEM_TIMEOUT=0 disables the timeout).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clock,
   input  logic clear_n,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   localparam bit ENABLED = (MEM_TIMEOUT > 0);
   localparam int WW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int LIM_I   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [WW-1:0] LIMIT = LIM_I[WW-1:0];

   logic [WW-1:0] count;
   logic          stalled;

   assign stalled = waiting & ~mem_ready;
   // The stored count lags by one: this stalled cycle is the MEM_TIMEOUT-th.
   assign timeout = ENABLED && stalled && (count == LIMIT);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (!ENABLED || !stalled || timeout) begin
         count <= '0;
      end else begin
         count <= count + WW'(1);
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, waits on mem_ready, counts cycles and retired fetches.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 clock,
   input  logic                 clear_n,
   input  logic                 run,
   input  logic [5:0]           opcode,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_dst,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           pc_source,
   output logic [3:0]           state,
   output logic                 halted,
   output logic                 mem_error,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   state_t cur;
   logic   waiting;
   logic   timeout;

   assign state   = cur;
   assign waiting = (cur == S_FETCH) || (cur == S_MEM_READ) || (cur == S_MEM_WRITE);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clock     (clock),
      .clear_n   (clear_n),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cur         <= S_IDLE;
         cycle_count <= '0;
         instr_count <= '0;
         mem_error   <= 1'b0;
      end else begin
         if (cur != S_IDLE && cur != S_HALT) cycle_count <= cycle_count + CNT_WIDTH'(1);
         if (cur == S_FETCH && mem_ready)    instr_count <= instr_count + CNT_WIDTH'(1);
         case (cur)
            S_IDLE:      if (run) cur <= S_FETCH;
            S_FETCH: begin
               if (mem_ready) begin
                  cur <= S_DECODE;
               end else if (timeout) begin
                  cur       <= S_HALT;
                  mem_error <= 1'b1;
               end
            end
            S_DECODE:    cur <= decode_next(opcode);
            S_MEM_ADDR: begin
               if (opcode == OP_LW)      cur <= S_MEM_READ;
               else if (opcode == OP_SW) cur <= S_MEM_WRITE;
               else                      cur <= S_HALT;
            end
            S_MEM_READ: begin
               if (mem_ready) begin
                  cur <= S_MEM_WB;
               end else if (timeout) begin
                  cur       <= S_HALT;
                  mem_error <= 1'b1;
               end
            end
            S_MEM_WRITE: begin
               if (mem_ready) begin
                  cur <= S_FETCH;
               end else if (timeout) begin
                  cur       <= S_HALT;
                  mem_error <= 1'b1;
               end
            end
            S_R_EXEC:    cur <= S_R_WB;
            S_ADDI_EXEC: cur <= S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: cur <= S_FETCH;
            S_HALT:      cur <= S_HALT;
            default:     cur <= S_HALT;
         endcase
      end
   end

   // Enables decode from the state register only; FETCH also gates on mem_ready.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      halted        = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:    alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB:   reg_write = 1'b1;
         S_HALT:      halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: an instruction-level model expands
// each instruction into expected per-cycle outputs, a negedge monitor compares.
module tb_multicycle_control;

   localparam int T  = 4;
   localparam int CW = 32;
   localparam int W  = 22 + 2 * CW;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_READ = 4;
   localparam int S_MEM_WB = 5, S_MEM_WRITE = 6, S_R_EXEC = 7, S_R_WB = 8, S_BRANCH = 9;
   localparam int S_JUMP = 10, S_ADDI_EXEC = 11, S_ADDI_WB = 12, S_HALT = 15;

   logic          clock = 1'b0;
   logic          clear_n = 1'b0;
   logic          run = 1'b0;
   logic [5:0]    opcode = 6'h00;
   logic          mem_ready = 1'b0;
   logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic          mem_to_reg, reg_dst, reg_write, alu_src_a, halted, mem_error;
   logic [1:0]    alu_src_b, alu_op, pc_source;
   logic [3:0]    state;
   logic [CW-1:0] cycle_count, instr_count;

   always #5 clock = ~clock;

   multicycle_control #(.CNT_WIDTH(CW), .MEM_TIMEOUT(T)) dut (
      .clock         (clock),
      .clear_n       (clear_n),
      .run           (run),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state         (state),
      .halted        (halted),
      .mem_error     (mem_error),
      .cycle_count   (cycle_count),
      .instr_count   (instr_count)
   );

   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            failures = 0;
   logic [CW-1:0] m_cyc = '0;
   logic [CW-1:0] m_ins = '0;
   bit            m_err = 1'b0;
   bit            m_halt = 1'b0;

   // Expected control vector of one cycle, straight from the per-state output table.
   function automatic logic [21:0] ctrl_vec(input int st, input logic rdy, input bit err);
      logic       pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, hl;
      logic [1:0] sb, ao, ps;
      logic [3:0] s4;
      pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0;
      sa = 0; hl = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
      s4 = st[3:0];
      case (st)
         S_FETCH:     begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         S_DECODE:    sb = 2'b11;
         S_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
         S_MEM_READ:  begin mr = 1; iod = 1; end
         S_MEM_WB:    begin rw = 1; m2r = 1; end
         S_MEM_WRITE: begin mw = 1; iod = 1; end
         S_R_EXEC:    begin sa = 1; ao = 2'b10; end
         S_R_WB:      begin rw = 1; rd = 1; end
         S_BRANCH:    begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
         S_JUMP:      begin pw = 1; ps = 2'b10; end
         S_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
         S_ADDI_WB:   rw = 1;
         S_HALT:      hl = 1;
         default: ;
      endcase
      return {s4, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, hl, err};
   endfunction

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rand_legal();
      logic [5:0] ops[6];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
      return ops[$urandom_range(0, 5)];
   endfunction

   function automatic logic [5:0] rand_illegal();
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08)
         op = 6'($urandom_range(0, 63));
      return op;
   endfunction

   // One clock cycle spent in state st; called just after a rising edge.
   task automatic step(input int st, input logic rdy, input logic rn);
      mem_ready = rdy;
      run       = rn;
      exp_q.push_back({ctrl_vec(st, rdy, m_err), m_cyc, m_ins});
      if (st != S_IDLE && st != S_HALT) m_cyc = m_cyc + 1;
      if (st == S_FETCH && rdy) m_ins = m_ins + 1;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_phase(input int st, input int stall, output bit timed_out);
      timed_out = 1'b0;
      for (int k = 0; k < stall; k++) begin
         step(st, 1'b0, rbit());
         if (k + 1 == T) begin
            m_err     = 1'b1;
            timed_out = 1'b1;
            return;
         end
      end
      step(st, 1'b1, rbit());
   endtask

   task automatic do_instr(input logic [5:0] op, input int fs, input int ms);
      bit to;
      opcode = op;
      wait_phase(S_FETCH, fs, to);
      if (to) begin
         m_halt = 1'b1;
         return;
      end
      step(S_DECODE, rbit(), rbit());
      case (op)
         6'h00: begin step(S_R_EXEC, rbit(), rbit()); step(S_R_WB, rbit(), rbit()); end
         6'h23: begin
            step(S_MEM_ADDR, rbit(), rbit());
            wait_phase(S_MEM_READ, ms, to);
            if (to) m_halt = 1'b1;
            else    step(S_MEM_WB, rbit(), rbit());
         end
         6'h2B: begin
            step(S_MEM_ADDR, rbit(), rbit());
            wait_phase(S_MEM_WRITE, ms, to);
            if (to) m_halt = 1'b1;
         end
         6'h04: step(S_BRANCH, rbit(), rbit());
         6'h02: step(S_JUMP, rbit(), rbit());
         6'h08: begin step(S_ADDI_EXEC, rbit(), rbit()); step(S_ADDI_WB, rbit(), rbit()); end
         default: m_halt = 1'b1;
      endcase
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         opcode = 6'($urandom_range(0, 63));
         step(S_HALT, rbit(), rbit());
      end
   endtask

   // Reset is asserted just after an edge, so the same cycle must already read IDLE.
   task automatic do_reset();
      clear_n = 1'b0;
      run     = 1'b0;
      m_cyc   = '0;
      m_ins   = '0;
      m_err   = 1'b0;
      m_halt  = 1'b0;
      exp_q.push_back({ctrl_vec(S_IDLE, 1'b0, 1'b0), {CW{1'b0}}, {CW{1'b0}}});
      @(posedge clock);
      #1;
      clear_n = 1'b1;
   endtask

   task automatic start();
      step(S_IDLE, rbit(), 1'b0);
      step(S_IDLE, rbit(), 1'b1);
   endtask

   logic [W-1:0]  exp_v;
   logic [21:0]   act_ctrl;

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_v    = exp_q.pop_front();
         act_ctrl = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                     halted, mem_error};
         checks++;
         if (act_ctrl !== exp_v[W-1:2*CW]) begin
            failures++;
            $display("FAIL ctrl t=%0t: got state=%0d bits=%b, required state=%0d bits=%b",
                     $time, act_ctrl[21:18], act_ctrl, exp_v[W-1:W-4], exp_v[W-1:2*CW]);
         end
         checks++;
         if (cycle_count !== exp_v[2*CW-1:CW]) begin
            failures++;
            $display("FAIL cycle_count t=%0t: got %0d, required %0d", $time, cycle_count, exp_v[2*CW-1:CW]);
         end
         checks++;
         if (instr_count !== exp_v[CW-1:0]) begin
            failures++;
            $display("FAIL instr_count t=%0t: got %0d, required %0d", $time, instr_count, exp_v[CW-1:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      clear_n = 1'b0;
      @(posedge clock);
      #1;
      do_reset();

      // Directed instruction sequences.
      start();
      do_instr(6'h00, 0, 0);
      do_instr(6'h23, 3, 2);
      do_instr(6'h2B, 1, 1);
      do_instr(6'h04, 0, 0);
      do_instr(6'h02, 0, 0);
      do_instr(6'h08, 2, 0);

      // Random legal stream, stalls below the timeout.
      repeat (40) do_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3));

      // Illegal opcode halts, counters freeze, run is ignored.
      do_instr(6'h3F, 0, 0);
      halt_cycles(6);
      do_reset();

      // Fetch timeout.
      start();
      do_instr(rand_legal(), 10, 0);
      halt_cycles(5);
      do_reset();

      // Load data timeout.
      start();
      do_instr(6'h23, 0, 7);
      halt_cycles(3);
      do_reset();

      // Reset in the middle of a store.
      start();
      opcode = 6'h2B;
      step(S_FETCH, 1'b1, 1'b0);
      step(S_DECODE, 1'b0, 1'b0);
      step(S_MEM_ADDR, 1'b1, 1'b0);
      step(S_MEM_WRITE, 1'b0, 1'b1);
      step(S_MEM_WRITE, 1'b0, 1'b0);
      do_reset();

      // Mixed random stream with illegal opcodes and timeouts.
      start();
      repeat (60) begin
         op = ($urandom_range(0, 9) == 0) ? rand_illegal() : rand_legal();
         do_instr(op, $urandom_range(0, 5), $urandom_range(0, 5));
         if (m_halt) begin
            halt_cycles($urandom_range(1, 4));
            do_reset();
            start();
         end
      end

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
